periph_btn_input: RTL and testbench

Memory-mapped button input peripheral for the 10 MHz CPU. Conditions the four raw Basys3 push-buttons (boton0..3): synchronises them, debounces each one, captures press events in sticky registers, and raises an interrupt request. It sits between the board button pins and the CPU data bus, and replaces the direct raw-button path into the CPU.

---
 rtl/periph_pkg.sv | 18 +
 rtl/btn_debounce_ch.sv | 56 +++++
 rtl/periph_btn_input.sv | 92 +++++++++
 tb/tb_periph_btn_input.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/periph_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : periph_pkg
// Brief   : Shared register offsets, types and defaults for CPU peripherals.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package periph_pkg;

  localparam logic [1:0] BTN_STATE_OFS = 2'd0;
  localparam logic [1:0] BTN_EVENT_OFS = 2'd1;
  localparam logic [1:0] BTN_IRQEN_OFS = 2'd2;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 100000;

  typedef logic [31:0] btn_reg_t;

endpackage
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : btn_debounce_ch
// Brief   : One button channel: 2-FF synchroniser, debounce counter, stable
//           level and a one-cycle pulse on each stable rising edge.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module btn_debounce_ch
  import periph_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int              CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] C_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic [CNT_W-1:0] r_cnt;

  // Any return to the stable level restarts the count, so bounces never accumulate.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= btn_i;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == C_TERM) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign stable_o = r_stable;
  assign rise_o   = r_stable & ~r_stable_d;

endmodule
`default_nettype wire

// File: rtl/periph_btn_input.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : periph_btn_input
// Brief   : Memory-mapped debounced button peripheral with sticky press
//           events (W1C), per-button interrupt enables and a level IRQ.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module periph_btn_input
  import periph_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_BTN-1:0] btn_i,
  input  logic             sel_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [1:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic             irq_o
);

  logic [N_BTN-1:0] w_stable;
  logic [N_BTN-1:0] w_rise;
  logic [N_BTN-1:0] w_clr;
  logic             w_wr;
  logic             w_rd;
  btn_reg_t         w_rdata;
  logic             w_unused;

  logic [N_BTN-1:0] r_event;
  logic [N_BTN-1:0] r_irqen;
  btn_reg_t         r_rdata;
  logic             r_irq;

  generate
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .btn_i   (btn_i[i]),
        .stable_o(w_stable[i]),
        .rise_o  (w_rise[i])
      );
    end
  endgenerate

  assign w_wr     = sel_i & we_i;
  assign w_rd     = sel_i & re_i;
  assign w_clr    = (w_wr && (addr_i == BTN_EVENT_OFS)) ? wdata_i[N_BTN-1:0] : '0;
  assign w_unused = ^wdata_i[31:N_BTN];

  // Read mux sees pre-write register values, so a same-cycle write is not visible.
  always_comb begin
    w_rdata = '0;
    case (addr_i)
      BTN_STATE_OFS: w_rdata[N_BTN-1:0] = w_stable;
      BTN_EVENT_OFS: w_rdata[N_BTN-1:0] = r_event;
      BTN_IRQEN_OFS: w_rdata[N_BTN-1:0] = r_irqen;
      default:       w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_event <= '0;
      r_irqen <= '0;
      r_rdata <= '0;
      r_irq   <= 1'b0;
    end else begin
      // Set after clear: a press coinciding with a W1C write is never lost.
      r_event <= (r_event & ~w_clr) | w_rise;
      if (w_wr && (addr_i == BTN_IRQEN_OFS)) begin
        r_irqen <= wdata_i[N_BTN-1:0];
      end
      if (w_rd) begin
        r_rdata <= w_rdata;
      end
      r_irq <= |(r_event & r_irqen);
    end
  end

  assign rdata_o = r_rdata;
  assign irq_o   = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_periph_btn_input.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_periph_btn_input
// Brief   : Directed self-checking bench for periph_btn_input (debounce 16).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_periph_btn_input;

  localparam int N_BTN = 4;
  localparam int DEB   = 16;

  logic             clk;
  logic             rst_n;
  logic [N_BTN-1:0] btn;
  logic             sel;
  logic             we;
  logic             re;
  logic [1:0]       addr;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic             irq;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  logic [31:0] d;

  periph_btn_input #(
    .N_BTN          (N_BTN),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .btn_i  (btn),
    .sel_i  (sel),
    .we_i   (we),
    .re_i   (re),
    .addr_i (addr),
    .wdata_i(wdata),
    .rdata_o(rdata),
    .irq_o  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] data);
    sel  = 1'b1;
    re   = 1'b1;
    addr = a;
    tick(1);
    data = rdata;
    sel  = 1'b0;
    re   = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    sel   = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = v;
    tick(1);
    sel   = 1'b0;
    we    = 1'b0;
    wdata = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = '0;
    sel   = 1'b0;
    we    = 1'b0;
    re    = 1'b0;
    addr  = 2'd0;
    wdata = '0;
    tick(3);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;
    tick(2);
    rd(2'd0, d); chk("rst_state", d, 32'h0);
    rd(2'd2, d); chk("rst_irqen", d, 32'h0);

    // Clean press on btn0: stable must change exactly DEB+2 edges after the input edge.
    sel = 1'b1; re = 1'b1; addr = 2'd0;
    btn[0] = 1'b1;
    tick(DEB + 2);
    chk("press_state_early", rdata, 32'h0);
    tick(1);
    chk("press_state_edge", rdata, 32'h1);
    addr = 2'd1;
    tick(1);
    chk("press_event", rdata, 32'h1);
    chk("press_irq_disabled", {31'b0, irq}, 32'h0);
    sel = 1'b0; re = 1'b0;
    wr(2'd1, 32'h1);
    rd(2'd1, d); chk("w1c_clear", d, 32'h0);
    btn[0] = 1'b0;
    tick(DEB + 4);
    rd(2'd0, d); chk("release_state", d, 32'h0);
    rd(2'd1, d); chk("release_no_event", d, 32'h0);

    // Bounce on btn2: 12 toggles of 5 cycles each, ending low.
    sel = 1'b1; re = 1'b1; addr = 2'd0;
    for (int i = 0; i < 12; i++) begin
      btn[2] = ~btn[2];
      tick(5);
      chk($sformatf("bounce_state_%0d", i), rdata, 32'h0);
    end
    btn[2] = 1'b1;
    tick(DEB + 2);
    chk("bounce_state_early", rdata, 32'h0);
    tick(1);
    chk("bounce_state_edge", rdata, 32'h4);
    sel = 1'b0; re = 1'b0;
    rd(2'd1, d); chk("bounce_event", d, 32'h4);
    wr(2'd1, 32'h4);
    tick(30);
    rd(2'd1, d); chk("bounce_event_once", d, 32'h0);
    btn[2] = 1'b0;
    tick(DEB + 4);

    // Glitch on btn1 one cycle shorter than the debounce window.
    btn[1] = 1'b1;
    tick(DEB - 1);
    btn[1] = 1'b0;
    tick(DEB + 10);
    rd(2'd0, d); chk("glitch_state", d, 32'h0);
    rd(2'd1, d); chk("glitch_event", d, 32'h0);

    // Register map: upper IRQ_EN bits, read-only STATE, reserved offset.
    wr(2'd2, 32'hFFFF_FFF5);
    rd(2'd2, d); chk("irqen_rw", d, 32'h5);
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, d); chk("state_ro", d, 32'h0);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, d); chk("reserved_rd", d, 32'h0);
    wr(2'd2, 32'h5);
    sel = 1'b0; re = 1'b1; addr = 2'd2;
    tick(1);
    chk("re_without_sel", rdata, 32'h0);
    re = 1'b0;
    sel = 1'b0; we = 1'b1; addr = 2'd2; wdata = 32'h0;
    tick(1);
    we = 1'b0;
    rd(2'd2, d); chk("we_without_sel", d, 32'h5);

    // IRQ and W1C with IRQ_EN = 0101.
    btn = 4'b1001;
    tick(DEB + 6);
    rd(2'd1, d); chk("irq_event", d, 32'h9);
    chk("irq_high", {31'b0, irq}, 32'h1);
    wr(2'd1, 32'h1);
    chk("irq_hold_after_clr", {31'b0, irq}, 32'h1);
    tick(1);
    chk("irq_low_after_clr", {31'b0, irq}, 32'h0);
    rd(2'd1, d); chk("event_after_clr", d, 32'h8);
    wr(2'd2, 32'h8);
    chk("irq_before_en", {31'b0, irq}, 32'h0);
    tick(1);
    chk("irq_after_en", {31'b0, irq}, 32'h1);
    wr(2'd1, 32'hF);
    wr(2'd2, 32'h0);
    tick(1);
    chk("irq_cleared", {31'b0, irq}, 32'h0);
    btn = '0;
    tick(DEB + 4);

    // Set/clear collision on EVENT[0], with a same-cycle read of EVENT.
    btn[0] = 1'b1;
    tick(DEB + 2);
    sel = 1'b1; we = 1'b1; re = 1'b1; addr = 2'd1; wdata = 32'h1;
    tick(1);
    chk("collide_read_old", rdata, 32'h0);
    we = 1'b0; wdata = '0;
    tick(1);
    chk("collide_set_wins", rdata, 32'h1);
    sel = 1'b0; re = 1'b0;

    // Reset mid-run with all buttons active and state/events/irq non-zero.
    wr(2'd2, 32'h1);
    tick(1);
    chk("pre_rst_irq", {31'b0, irq}, 32'h1);
    btn = 4'hF;
    tick(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_irq", {31'b0, irq}, 32'h0);
    tick(2);
    btn = '0;
    rst_n = 1'b1;
    tick(1);
    rd(2'd0, d); chk("postrst_state", d, 32'h0);
    rd(2'd1, d); chk("postrst_event", d, 32'h0);
    rd(2'd2, d); chk("postrst_irqen", d, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
